exu_trap: RTL and testbench
===========================

# exu_trap

Trap-entry and trap-return sequencer for the core's execute stage. It accepts a trap request (`int_ena` plus a 32-bit `mcause`) from the EXU interrupt/exception controller, or an `mret` from the decoder. It then updates the machine-mode trap CSRs and issues a one-shot PC redirect with pipeline flush to the fetch unit. It owns mstatus (MIE/MPIE), mtvec, mepc, mcause and mtval, and serves software CSR reads and writes to them.

## Interface
- `MTVEC_RST`, 32'h0000_0000, reset value of mtvec.
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `hs_ex4tr_vld`  in  1  request valid from EXU: trap or mret.
- `hs_ex4tr_rdy`  out  1  block can accept a request.
- `i_int_ena`  in  1  request is a trap; sampled with the request.
- `i_mcause`  in  32  trap cause; bit31 = interrupt.
- `i_mret`  in  1  request is an mret.
- `i_pc`  in  32  PC of the trapping instruction.
- `i_mtval`  in  32  trap value.
- `o_redir_vld`  out  1  redirect/flush request to fetch.
- `hs_redir_rdy`  in  1  fetch accepts the redirect.
- `o_redir_pc`  out  32  redirect target.
- `o_flush`  out  1  equals `o_redir_vld`.
- `o_mie`  out  1  current mstatus.MIE, for interrupt masking upstream.
- `i_csr_addr`  in  12  software CSR address.
- `i_csr_wen`  in  1  software CSR write strobe.
- `i_csr_wdata`  in  32  software CSR write data.
- `o_csr_rdata`  out  32  combinational read of the addressed CSR; 0 for unmapped addresses.

## Operation
- FSM states: IDLE, REDIR.
  - `hs_ex4tr_rdy` = (state == IDLE).
  - `o_redir_vld` = (state == REDIR).
- Accept happens on `hs_ex4tr_vld & hs_ex4tr_rdy`:
  - `i_int_ena`=1 is a trap. If both `i_int_ena` and `i_mret` are set, the trap wins.
  - `i_int_ena`=0 with `i_mret`=1 is an mret.
  - Both 0: the request is consumed with no effect and the FSM stays in IDLE.
- Trap accept edge:
  - mepc <= {i_pc[31:2], 2'b00}
  - mcause <= i_mcause
  - mtval <= i_mtval
  - MPIE <= MIE; MIE <= 0
  - redirect target latched; state -> REDIR.
- Trap target:
  - If mtvec[1:0]==2'b01 and i_mcause[31]=1: {mtvec[31:2],2'b00} + (i_mcause[29:0] << 2). The sum is 32 bits and wraps.
  - Otherwise: {mtvec[31:2],2'b00}.
- mret accept edge:
  - MIE <= MPIE; MPIE <= 1
  - target <= mepc; state -> REDIR.
- REDIR: `o_redir_pc` is held stable. On `hs_redir_rdy`, the FSM returns to IDLE on that edge.
- CSR map and field rules:
  - 0x300 mstatus: bit3 MIE, bit7 MPIE, bits[12:11] read 2'b11; all other bits read 0 and ignore writes.
  - 0x305 mtvec: full 32-bit R/W.
  - 0x341 mepc: bits[1:0] read 0.
  - 0x342 mcause: full 32-bit R/W.
  - 0x343 mtval: full 32-bit R/W.
- Software writes take effect on the edge and are allowed in any state.
- When a software write and a trap/mret update target the same CSR on the same edge, the trap/mret update wins. Non-conflicting fields and registers still take the software write.
- An mret uses the mepc value from before any same-edge write.

## Timing
- Reset values:
  - state = IDLE; `hs_ex4tr_rdy`=1; `o_redir_vld`=`o_flush`=0; `o_redir_pc`=0.
  - MIE=MPIE=0 (`o_mie`=0); mtvec=`MTVEC_RST`; mepc=mcause=mtval=0.
- Accept at edge T: CSRs show new values from T+1. `o_redir_vld`=1 from T+1.
- Minimum request-to-redirect latency is 1 cycle. If `hs_redir_rdy` is held high, a new request is accepted every 2 cycles.
- `hs_ex4tr_rdy` is 0 throughout REDIR. Requests presented then are not consumed; the EXU holds them.
- Reset asserted in REDIR: the pending redirect is dropped and all state returns to reset values on that edge.
- `o_csr_rdata` has zero latency (combinational on address and current register values).

## Test plan
- Reset, then read each CSR:
  - mstatus=32'h0000_1800, mtvec=`MTVEC_RST`, others 0.
  - `hs_ex4tr_rdy`=1, `o_redir_vld`=0.
- mtvec=32'h8000_0100 (direct); MIE=1; trap with mcause=32'h0000_000B, pc=32'h0000_2006, `hs_redir_rdy`=1:
  - Next cycle `o_redir_vld`=1, pc=32'h8000_0100.
  - mepc=32'h0000_2004, MPIE=1, MIE=0.
  - Back in IDLE after 2 cycles total.
- mtvec=32'h8000_0101 (vectored); trap with mcause=32'h8000_0007:
  - Redirect pc=32'h8000_011C.
  - Same vector with mcause=32'h0000_0002: pc=32'h8000_0100.
- mret after the trap above, MPIE=1:
  - Redirect pc=mepc; MIE=1, MPIE=1.
  - Request with `i_int_ena`=`i_mret`=1 behaves as a trap.
- Stall `hs_redir_rdy`=0 for 5 cycles:
  - `o_redir_vld` and `o_redir_pc` stay stable.
  - `hs_ex4tr_rdy`=0 and a second request is not consumed.
  - Reset during the stall clears `o_redir_vld` on the next cycle.
- Software write of 32'hFFFF_FFFF to mcause on the same edge as a trap with mcause=32'h0000_0003: mcause reads 32'h0000_0003.

Source files
------------

// File: rtl/exu_trap.sv
// Trap-entry / mret sequencer for the execute stage: owns the machine trap CSRs
// and issues a one-shot PC redirect with pipeline flush to fetch.
module exu_trap #(
    parameter logic [31:0] MTVEC_RST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hs_ex4tr_vld,
    output logic        hs_ex4tr_rdy,
    input  logic        i_int_ena,
    input  logic [31:0] i_mcause,
    input  logic        i_mret,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_mtval,
    output logic        o_redir_vld,
    input  logic        hs_redir_rdy,
    output logic [31:0] o_redir_pc,
    output logic        o_flush,
    output logic        o_mie,
    input  logic [11:0] i_csr_addr,
    input  logic        i_csr_wen,
    input  logic [31:0] i_csr_wdata,
    output logic [31:0] o_csr_rdata
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_REDIR = 1'b1
    } state_t;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_mie;
    logic        r_mpie;
    logic [31:0] r_mtvec;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;
    logic [31:0] r_mtval;
    logic [31:0] r_redir_pc;

    logic        w_accept;
    logic        w_trap;
    logic        w_mret;
    logic [31:0] w_mtvec_base;
    logic [31:0] w_trap_tgt;
    logic        w_wr_mstatus;
    logic        w_wr_mtvec;
    logic        w_wr_mepc;
    logic        w_wr_mcause;
    logic        w_wr_mtval;

    assign hs_ex4tr_rdy = (r_state == S_IDLE);
    assign o_redir_vld  = (r_state == S_REDIR);
    assign o_flush      = o_redir_vld;
    assign o_redir_pc   = r_redir_pc;
    assign o_mie        = r_mie;

    // Trap takes priority when both trap and mret are flagged.
    assign w_accept = hs_ex4tr_vld & hs_ex4tr_rdy;
    assign w_trap   = w_accept & i_int_ena;
    assign w_mret   = w_accept & ~i_int_ena & i_mret;

    assign w_mtvec_base = {r_mtvec[31:2], 2'b00};
    assign w_trap_tgt   = ((r_mtvec[1:0] == 2'b01) && i_mcause[31])
                        ? w_mtvec_base + {i_mcause[29:0], 2'b00}
                        : w_mtvec_base;

    assign w_wr_mstatus = i_csr_wen && (i_csr_addr == CSR_MSTATUS);
    assign w_wr_mtvec   = i_csr_wen && (i_csr_addr == CSR_MTVEC);
    assign w_wr_mepc    = i_csr_wen && (i_csr_addr == CSR_MEPC);
    assign w_wr_mcause  = i_csr_wen && (i_csr_addr == CSR_MCAUSE);
    assign w_wr_mtval   = i_csr_wen && (i_csr_addr == CSR_MTVAL);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_trap || w_mret) w_state_nxt = S_REDIR;
            S_REDIR: if (hs_redir_rdy)     w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Hardware trap/mret updates override a same-edge software write to the same CSR.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mie      <= 1'b0;
            r_mpie     <= 1'b0;
            r_mtvec    <= MTVEC_RST;
            r_mepc     <= '0;
            r_mcause   <= '0;
            r_mtval    <= '0;
            r_redir_pc <= '0;
        end else begin
            if (w_trap) begin
                r_mpie <= r_mie;
                r_mie  <= 1'b0;
            end else if (w_mret) begin
                r_mie  <= r_mpie;
                r_mpie <= 1'b1;
            end else if (w_wr_mstatus) begin
                r_mie  <= i_csr_wdata[3];
                r_mpie <= i_csr_wdata[7];
            end

            if (w_wr_mtvec) r_mtvec <= i_csr_wdata;

            if (w_trap)         r_mepc <= {i_pc[31:2], 2'b00};
            else if (w_wr_mepc) r_mepc <= {i_csr_wdata[31:2], 2'b00};

            if (w_trap)           r_mcause <= i_mcause;
            else if (w_wr_mcause) r_mcause <= i_csr_wdata;

            if (w_trap)          r_mtval <= i_mtval;
            else if (w_wr_mtval) r_mtval <= i_csr_wdata;

            if (w_trap)      r_redir_pc <= w_trap_tgt;
            else if (w_mret) r_redir_pc <= r_mepc;
        end
    end

    always_comb begin
        o_csr_rdata = '0;
        case (i_csr_addr)
            CSR_MSTATUS: o_csr_rdata = {19'd0, 2'b11, 3'd0, r_mpie, 3'd0, r_mie, 3'd0};
            CSR_MTVEC:   o_csr_rdata = r_mtvec;
            CSR_MEPC:    o_csr_rdata = r_mepc;
            CSR_MCAUSE:  o_csr_rdata = r_mcause;
            CSR_MTVAL:   o_csr_rdata = r_mtval;
            default:     o_csr_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_exu_trap.sv
// Self-checking bench for exu_trap: redirect targets go through a scoreboard queue,
// CSR side effects and handshake behaviour are checked inline per scenario.
module tb_exu_trap;

    logic        clk;
    logic        rst;
    logic        hs_ex4tr_vld;
    logic        hs_ex4tr_rdy;
    logic        i_int_ena;
    logic [31:0] i_mcause;
    logic        i_mret;
    logic [31:0] i_pc;
    logic [31:0] i_mtval;
    logic        o_redir_vld;
    logic        hs_redir_rdy;
    logic [31:0] o_redir_pc;
    logic        o_flush;
    logic        o_mie;
    logic [11:0] i_csr_addr;
    logic        i_csr_wen;
    logic [31:0] i_csr_wdata;
    logic [31:0] o_csr_rdata;

    int          checks;
    int          errors;
    int          cyc;
    logic [31:0] sb[$];
    logic [31:0] m_exp;

    exu_trap #(.MTVEC_RST(32'h0000_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .hs_ex4tr_vld (hs_ex4tr_vld),
        .hs_ex4tr_rdy (hs_ex4tr_rdy),
        .i_int_ena    (i_int_ena),
        .i_mcause     (i_mcause),
        .i_mret       (i_mret),
        .i_pc         (i_pc),
        .i_mtval      (i_mtval),
        .o_redir_vld  (o_redir_vld),
        .hs_redir_rdy (hs_redir_rdy),
        .o_redir_pc   (o_redir_pc),
        .o_flush      (o_flush),
        .o_mie        (o_mie),
        .i_csr_addr   (i_csr_addr),
        .i_csr_wen    (i_csr_wen),
        .i_csr_wdata  (i_csr_wdata),
        .o_csr_rdata  (o_csr_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Redirect handshake completes on the next rising edge; compare against the scoreboard.
    always @(negedge clk) begin
        if (!rst && o_redir_vld && hs_redir_rdy) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL redir_unexpected: got pc=%h, required no redirect", o_redir_pc);
            end else begin
                m_exp = sb.pop_front();
                if (o_redir_pc !== m_exp || o_flush !== 1'b1) begin
                    errors++;
                    $display("FAIL redir_pc: got pc=%h flush=%b, required pc=%h flush=1",
                             o_redir_pc, o_flush, m_exp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_write(input logic [11:0] addr, input logic [31:0] data);
        i_csr_addr  = addr;
        i_csr_wdata = data;
        i_csr_wen   = 1'b1;
        tick();
        i_csr_wen   = 1'b0;
    endtask

    task automatic send_req(input logic ie, input logic mr, input logic [31:0] cause,
                            input logic [31:0] pc, input logic [31:0] tval,
                            input logic push, input logic [31:0] exp_pc);
        int unsigned n;
        n = 0;
        while (!hs_ex4tr_rdy && n < 50) begin
            tick();
            n++;
        end
        if (!hs_ex4tr_rdy) begin
            checks++;
            errors++;
            $display("FAIL req_rdy_timeout: got rdy=0, required rdy=1 within 50 cycles");
        end
        hs_ex4tr_vld = 1'b1;
        i_int_ena    = ie;
        i_mret       = mr;
        i_mcause     = cause;
        i_pc         = pc;
        i_mtval      = tval;
        if (push) sb.push_back(exp_pc);
        tick();
        hs_ex4tr_vld = 1'b0;
        i_int_ena    = 1'b0;
        i_mret       = 1'b0;
    endtask

    task automatic drain();
        int unsigned n;
        n = 0;
        while ((sb.size() != 0 || o_redir_vld) && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (sb.size() != 0 || o_redir_vld !== 1'b0) begin
            errors++;
            $display("FAIL drain_timeout: got pending=%0d vld=%b, required pending=0 vld=0",
                     sb.size(), o_redir_vld);
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick(); tick();
        rst = 1'b0;
        checks++;
        if (hs_ex4tr_rdy !== 1'b1 || o_redir_vld !== 1'b0 || o_flush !== 1'b0 ||
            o_redir_pc !== 32'h0 || o_mie !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b flush=%b pc=%h mie=%b, required 1 0 0 0 0",
                     hs_ex4tr_rdy, o_redir_vld, o_flush, o_redir_pc, o_mie);
        end
        i_csr_addr = 12'h300; #1;
        checks++;
        if (o_csr_rdata !== 32'h0000_1800) begin
            errors++; $display("FAIL reset_mstatus: got %h, required 00001800", o_csr_rdata);
        end
        i_csr_addr = 12'h305; #1;
        checks++;
        if (o_csr_rdata !== 32'h0) begin
            errors++; $display("FAIL reset_mtvec: got %h, required 00000000", o_csr_rdata);
        end
        i_csr_addr = 12'h341; #1;
        checks++;
        if (o_csr_rdata !== 32'h0) begin
            errors++; $display("FAIL reset_mepc: got %h, required 00000000", o_csr_rdata);
        end
        tick();
        i_csr_addr = 12'h342; #1;
        checks++;
        if (o_csr_rdata !== 32'h0) begin
            errors++; $display("FAIL reset_mcause: got %h, required 00000000", o_csr_rdata);
        end
        i_csr_addr = 12'h343; #1;
        checks++;
        if (o_csr_rdata !== 32'h0) begin
            errors++; $display("FAIL reset_mtval: got %h, required 00000000", o_csr_rdata);
        end
    endtask

    task automatic test_direct_trap();
        csr_write(12'h305, 32'h8000_0100);
        csr_write(12'h300, 32'h0000_0008);
        checks++;
        if (o_mie !== 1'b1) begin
            errors++; $display("FAIL mie_write: got %b, required 1", o_mie);
        end
        // unmapped address reads zero and write to it has no effect
        csr_write(12'h344, 32'h1234_5678);
        i_csr_addr = 12'h344; #1;
        checks++;
        if (o_csr_rdata !== 32'h0) begin
            errors++; $display("FAIL unmapped_read: got %h, required 00000000", o_csr_rdata);
        end
        send_req(1'b1, 1'b0, 32'h0000_000B, 32'h0000_2006, 32'hDEAD_BEEF, 1'b1, 32'h8000_0100);
        checks++;
        if (o_redir_vld !== 1'b1 || o_flush !== 1'b1 || o_redir_pc !== 32'h8000_0100 ||
            hs_ex4tr_rdy !== 1'b0 || o_mie !== 1'b0) begin
            errors++;
            $display("FAIL direct_redir: got vld=%b flush=%b pc=%h rdy=%b mie=%b, required 1 1 80000100 0 0",
                     o_redir_vld, o_flush, o_redir_pc, hs_ex4tr_rdy, o_mie);
        end
        i_csr_addr = 12'h341; #1;
        checks++;
        if (o_csr_rdata !== 32'h0000_2004) begin
            errors++; $display("FAIL direct_mepc: got %h, required 00002004", o_csr_rdata);
        end
        i_csr_addr = 12'h300; #1;
        checks++;
        if (o_csr_rdata !== 32'h0000_1880) begin
            errors++; $display("FAIL direct_mstatus: got %h, required 00001880", o_csr_rdata);
        end
        i_csr_addr = 12'h343; #1;
        checks++;
        if (o_csr_rdata !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL direct_mtval: got %h, required deadbeef", o_csr_rdata);
        end
        tick();
        checks++;
        if (hs_ex4tr_rdy !== 1'b1 || o_redir_vld !== 1'b0) begin
            errors++;
            $display("FAIL direct_idle: got rdy=%b vld=%b, required rdy=1 vld=0", hs_ex4tr_rdy, o_redir_vld);
        end
        drain();
        // a request with neither trap nor mret is consumed without effect
        send_req(1'b0, 1'b0, 32'h0000_0001, 32'h0000_9000, 32'h0, 1'b0, 32'h0);
        i_csr_addr = 12'h341; #1;
        checks++;
        if (o_redir_vld !== 1'b0 || hs_ex4tr_rdy !== 1'b1 || o_csr_rdata !== 32'h0000_2004) begin
            errors++;
            $display("FAIL noop_req: got vld=%b rdy=%b mepc=%h, required 0 1 00002004",
                     o_redir_vld, hs_ex4tr_rdy, o_csr_rdata);
        end
    endtask

    task automatic test_vectored();
        csr_write(12'h305, 32'h8000_0101);
        send_req(1'b1, 1'b0, 32'h8000_0007, 32'h0000_2100, 32'h0, 1'b1, 32'h8000_011C);
        i_csr_addr = 12'h342; #1;
        checks++;
        if (o_csr_rdata !== 32'h8000_0007) begin
            errors++; $display("FAIL vec_mcause: got %h, required 80000007", o_csr_rdata);
        end
        drain();
        send_req(1'b1, 1'b0, 32'h0000_0002, 32'h0000_2200, 32'h0, 1'b1, 32'h8000_0100);
        drain();
        // vectored target wraps past 2^32
        csr_write(12'h305, 32'hFFFF_FFF1);
        send_req(1'b1, 1'b0, 32'h8000_0004, 32'h0000_2300, 32'h0, 1'b1, 32'h0000_0000);
        drain();
        csr_write(12'h305, 32'h8000_0101);
    endtask

    task automatic test_mret();
        csr_write(12'h300, 32'h0000_0008);
        send_req(1'b1, 1'b0, 32'h0000_000B, 32'h0000_3008, 32'h0, 1'b1, 32'h8000_0100);
        drain();
        send_req(1'b0, 1'b1, 32'h0, 32'h0000_5000, 32'h0, 1'b1, 32'h0000_3008);
        i_csr_addr = 12'h300; #1;
        checks++;
        if (o_csr_rdata !== 32'h0000_1888 || o_mie !== 1'b1) begin
            errors++;
            $display("FAIL mret_mstatus: got %h mie=%b, required 00001888 mie=1", o_csr_rdata, o_mie);
        end
        drain();
        send_req(1'b1, 1'b1, 32'h0000_0005, 32'h0000_4000, 32'h0, 1'b1, 32'h8000_0100);
        i_csr_addr = 12'h341; #1;
        checks++;
        if (o_csr_rdata !== 32'h0000_4000) begin
            errors++; $display("FAIL both_mepc: got %h, required 00004000", o_csr_rdata);
        end
        i_csr_addr = 12'h300; #1;
        checks++;
        if (o_csr_rdata !== 32'h0000_1880) begin
            errors++; $display("FAIL both_mstatus: got %h, required 00001880", o_csr_rdata);
        end
        drain();
    endtask

    task automatic test_sw_conflict();
        i_csr_addr  = 12'h342;
        i_csr_wdata = 32'hFFFF_FFFF;
        i_csr_wen   = 1'b1;
        send_req(1'b1, 1'b0, 32'h0000_0003, 32'h0000_4100, 32'h0, 1'b1, 32'h8000_0100);
        i_csr_wen   = 1'b0;
        i_csr_addr  = 12'h342; #1;
        checks++;
        if (o_csr_rdata !== 32'h0000_0003) begin
            errors++; $display("FAIL conflict_mcause: got %h, required 00000003", o_csr_rdata);
        end
        drain();
        // mret redirects to the old mepc while the same-edge write lands
        i_csr_addr  = 12'h341;
        i_csr_wdata = 32'h0000_5553;
        i_csr_wen   = 1'b1;
        send_req(1'b0, 1'b1, 32'h0, 32'h0, 32'h0, 1'b1, 32'h0000_4100);
        i_csr_wen   = 1'b0;
        i_csr_addr  = 12'h341; #1;
        checks++;
        if (o_csr_rdata !== 32'h0000_5550) begin
            errors++; $display("FAIL mret_mepc_write: got %h, required 00005550", o_csr_rdata);
        end
        drain();
    endtask

    task automatic test_stall();
        hs_redir_rdy = 1'b0;
        send_req(1'b1, 1'b0, 32'h0000_0001, 32'h0000_6000, 32'h0, 1'b1, 32'h8000_0100);
        hs_ex4tr_vld = 1'b1;
        i_int_ena    = 1'b1;
        i_mcause     = 32'h0000_0002;
        i_pc         = 32'h0000_7000;
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (o_redir_vld !== 1'b1 || o_redir_pc !== 32'h8000_0100 || hs_ex4tr_rdy !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got vld=%b pc=%h rdy=%b, required 1 80000100 0",
                         k, o_redir_vld, o_redir_pc, hs_ex4tr_rdy);
            end
            tick();
        end
        hs_ex4tr_vld = 1'b0;
        i_int_ena    = 1'b0;
        i_csr_addr   = 12'h341; #1;
        checks++;
        if (o_csr_rdata !== 32'h0000_6000) begin
            errors++; $display("FAIL stall_not_consumed: got mepc=%h, required 00006000", o_csr_rdata);
        end
        hs_redir_rdy = 1'b1;
        drain();
        hs_redir_rdy = 1'b0;
        send_req(1'b1, 1'b0, 32'h0000_0002, 32'h0000_7000, 32'h0, 1'b1, 32'h8000_0100);
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        i_csr_addr = 12'h341; #1;
        checks++;
        if (o_redir_vld !== 1'b0 || hs_ex4tr_rdy !== 1'b1 || o_redir_pc !== 32'h0 ||
            o_csr_rdata !== 32'h0) begin
            errors++;
            $display("FAIL stall_reset: got vld=%b rdy=%b pc=%h mepc=%h, required 0 1 0 0",
                     o_redir_vld, hs_ex4tr_rdy, o_redir_pc, o_csr_rdata);
        end
        hs_redir_rdy = 1'b1;
    endtask

    task automatic test_back_to_back();
        int start;
        csr_write(12'h305, 32'h0000_1001);
        start = cyc;
        for (int k = 1; k <= 4; k++) begin
            logic [31:0] c;
            c = 32'h8000_0000 | k;
            send_req(1'b1, 1'b0, c, 32'h0000_8000, 32'h0, 1'b1, 32'h0000_1000 + (k * 4));
        end
        checks++;
        if (cyc - start !== 7) begin
            errors++; $display("FAIL b2b_rate: got %0d cycles, required 7", cyc - start);
        end
        drain();
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        cyc          = 0;
        rst          = 1'b1;
        hs_ex4tr_vld = 1'b0;
        i_int_ena    = 1'b0;
        i_mcause     = '0;
        i_mret       = 1'b0;
        i_pc         = '0;
        i_mtval      = '0;
        hs_redir_rdy = 1'b1;
        i_csr_addr   = '0;
        i_csr_wen    = 1'b0;
        i_csr_wdata  = '0;
        test_reset();
        test_direct_trap();
        test_vectored();
        test_mret();
        test_sw_conflict();
        test_stall();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
